// File: rtl/demux_frame_sequencer_if.sv
// Load handshake and serial demux drive between a controller and demux_frame_sequencer.
interface demux_frame_sequencer_if;
  logic       in_load;
  logic [3:0] in_word;
  logic [3:0] in_mask;
  logic       in_abort;
  logic       out_ready;
  logic       out_data;
  logic       out_selec0;
  logic       out_selec1;
  logic       out_valid;
  logic       out_done;

  modport master (
    output in_load, in_word, in_mask, in_abort,
    input  out_ready, out_data, out_selec0, out_selec1, out_valid, out_done
  );

  modport slave (
    input  in_load, in_word, in_mask, in_abort,
    output out_ready, out_data, out_selec0, out_selec1, out_valid, out_done
  );
endinterface

// File: rtl/demux_frame_sequencer.sv
// Serialises a masked 4-bit word onto the 1-to-4 demux, one enabled channel per clock.
//   state | meaning
//   IDLE  | ready for a load; empty-mask loads only pulse done
//   SEND  | driving word[ch] with selects from ch
//   GAP   | inter-frame pause of GAP_CYCLES cycles
module demux_frame_sequencer #(
  parameter int GAP_CYCLES = 1
) (
  input logic                    in_clk,
  input logic                    in_rst,
  demux_frame_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);
  localparam bit         HAS_GAP  = (GAP_CYCLES > 0);

  state_t     state, state_nxt;
  logic [3:0] word, word_nxt;
  logic [3:0] mask, mask_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [1:0] ch, ch_nxt;
  logic [1:0] sel_r, sel_nxt;
  logic       data_r, data_nxt;
  logic       valid_r, valid_nxt;
  logic       done_r, done_nxt;
  logic [2:0] pick;

  // Lowest set mask bit at or above 'from'; bit 2 of the result flags "none".
  function automatic logic [2:0] first_set(input logic [3:0] m, input logic [2:0] from);
    logic [2:0] r;
    r = 3'b100;
    for (int i = 3; i >= 0; i--) begin
      if (m[i] && (3'(i) >= from)) r = 3'(i);
    end
    return r;
  endfunction

  always_comb begin
    state_nxt = state;
    word_nxt  = word;
    mask_nxt  = mask;
    cnt_nxt   = cnt;
    ch_nxt    = ch;
    sel_nxt   = sel_r;
    data_nxt  = 1'b0;
    valid_nxt = 1'b0;
    done_nxt  = 1'b0;
    pick      = 3'b100;
    case (state)
      IDLE: begin
        if (bus.in_load) begin
          word_nxt = bus.in_word;
          mask_nxt = bus.in_mask;
          pick     = first_set(bus.in_mask, 3'd0);
          if (pick[2]) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt = SEND;
            ch_nxt    = pick[1:0];
            sel_nxt   = pick[1:0];
            data_nxt  = bus.in_word[pick[1:0]];
            valid_nxt = 1'b1;
          end
        end
      end
      SEND: begin
        if (bus.in_abort) begin
          state_nxt = IDLE;
        end else begin
          pick = first_set(mask, {1'b0, ch} + 3'd1);
          if (!pick[2]) begin
            ch_nxt    = pick[1:0];
            sel_nxt   = pick[1:0];
            data_nxt  = word[pick[1:0]];
            valid_nxt = 1'b1;
          end else begin
            done_nxt = 1'b1;
            if (HAS_GAP) begin
              state_nxt = GAP;
              cnt_nxt   = GAP_LOAD;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
      end
      GAP: begin
        if (bus.in_abort || cnt == 4'd0) state_nxt = IDLE;
        else                             cnt_nxt   = cnt - 4'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state   <= IDLE;
      word    <= 4'd0;
      mask    <= 4'd0;
      cnt     <= 4'd0;
      ch      <= 2'd0;
      sel_r   <= 2'd0;
      data_r  <= 1'b0;
      valid_r <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state   <= state_nxt;
      word    <= word_nxt;
      mask    <= mask_nxt;
      cnt     <= cnt_nxt;
      ch      <= ch_nxt;
      sel_r   <= sel_nxt;
      data_r  <= data_nxt;
      valid_r <= valid_nxt;
      done_r  <= done_nxt;
    end
  end

  assign bus.out_ready  = (state == IDLE);
  assign bus.out_data   = data_r;
  assign bus.out_valid  = valid_r;
  assign bus.out_done   = done_r;
  assign bus.out_selec0 = sel_r[1];
  assign bus.out_selec1 = sel_r[0];
endmodule

// File: doc/demux_frame_sequencer.md
# demux_frame_sequencer

Upstream stage of the 1-to-4 demultiplexer. Accepts a 4-bit parallel word with a channel-enable mask through a ready/valid load handshake. It then serialises the word onto the demux data input, one enabled channel per clock, driving the two select lines so that bit k reaches demux output y(k+1). An optional inter-frame gap and an abort input let the controller pace and cancel transfers.

## Interface
- GAP_CYCLES, default 1: idle cycles inserted after each frame before the next load is accepted; range 0..15.
- in_clk  input  1  clock; all state changes on the rising edge.
- in_rst  input  1  asynchronous, active-high reset.
- in_load  input  1  load request; qualified by out_ready.
- in_word  input  4  data word; bit k is destined for demux output y(k+1).
- in_mask  input  4  channel enable; bit k=1 sends bit k, bit k=0 skips channel k.
- in_abort  input  1  synchronous cancel of the frame in progress.
- out_ready  output  1  high exactly when in IDLE.
- out_data  output  1  serial bit to the demux data input; 0 whenever out_valid=0.
- out_selec0  output  1  demux first-stage select = channel index bit 1.
- out_selec1  output  1  demux second-stage select = channel index bit 0.
- out_valid  output  1  high on each cycle a bit is being delivered.
- out_done  output  1  one-cycle pulse after the last bit of a frame.

## Operation
- Channel mapping, fixed: ch0→(s0,s1)=(0,0)→y1; ch1→(0,1)→y2; ch2→(1,0)→y3; ch3→(1,1)→y4.
- States: IDLE, SEND, GAP. Registers: word[3:0], mask[3:0], ch[1:0], gap counter[3:0].
- IDLE:
  - in_load=1 captures in_word and in_mask.
  - If in_mask≠0: go to SEND with ch set to the lowest set mask bit.
  - If in_mask=0: the frame is empty. Stay in IDLE and pulse out_done on the next cycle; no out_valid.
- SEND: each cycle drives out_valid=1, out_data=word[ch], and the selects from ch.
  - If a higher mask bit is set, ch advances to the next higher set bit.
  - Otherwise the frame ends. Go to GAP if GAP_CYCLES>0, else IDLE, and pulse out_done in the following cycle.
  - Channels are always visited in ascending order. Captured word and mask stay frozen while the frame runs; input changes have no effect.
- GAP: out_ready=0, out_valid=0. The counter loads GAP_CYCLES-1 on entry and decrements; return to IDLE when it reads 0.
- in_abort=1 in SEND or GAP forces IDLE at the next edge, with no out_done pulse. In IDLE, in_abort has no effect and does not block a simultaneous in_load.
- in_load while out_ready=0 is ignored; it is not queued.
- Selects hold their last value when out_valid=0 (they go to 0 after reset). Consumers gate on out_valid.
- All outputs are registered except out_ready, which is decoded from the state.

## Timing
- Reset, asynchronous: state=IDLE, word, mask, ch and counter=0. Outputs: out_data=0, out_selec0=0, out_selec1=0, out_valid=0, out_done=0, out_ready=1.
- Reset asserted mid-frame truncates the frame immediately. No out_done is produced.
- Load accepted at edge N → first out_valid cycle is N+1.
- A frame with m enabled channels (m=1..4):
  - m consecutive out_valid cycles.
  - out_done is high for the cycle after the last one.
  - out_ready returns GAP_CYCLES cycles after the last out_valid cycle, so it overlaps out_done when GAP_CYCLES=0.
- Back-to-back throughput with GAP_CYCLES=0: one frame per m+1 cycles.

## Test plan
- Reset mid-frame:
  - Stimulus: assert in_rst during the 2nd SEND cycle.
  - Required response: all outputs 0 and out_ready=1 immediately, before the next clock edge; no out_done.
- Full frame, GAP_CYCLES=1:
  - Stimulus: in_word=4'b1010, in_mask=4'b1111.
  - Required response: out_data sequence 0,1,0,1 with (s0,s1)=(0,0),(0,1),(1,0),(1,1) on cycles N+1..N+4; out_done at N+5; out_ready back at N+6.
- Sparse mask:
  - Stimulus: in_word=4'b1111, in_mask=4'b1001.
  - Required response: exactly two valid cycles, with selects (0,0) then (1,1); out_data=1 both cycles.
- Empty mask:
  - Stimulus: in_mask=4'b0000.
  - Required response: no out_valid; one out_done pulse; out_ready stays 1.
- Abort:
  - Stimulus: in_mask=4'b1111, assert in_abort in the 2nd SEND cycle.
  - Required response: only 2 valid cycles, no out_done, out_ready=1 on the next cycle. Also check that in_load asserted during SEND is ignored.
- Demux integration, GAP_CYCLES=0:
  - Stimulus: back-to-back frames with in_word=4'b0110 and 4'b1001, all channels enabled, driving the demux.
  - Required response: y2,y3 pulse on the first frame; y1,y4 on the second; 5 cycles per frame.
